// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding plus pattern-table scheduler
// constants and state encoding.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam int TABLE_INDEX_WIDTH = 12;
    localparam int TABLE_CTR_WIDTH   = 2;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        UP_READ  = 2'd2,
        UP_WRITE = 2'd3
    } TableSchedState;

endpackage

// File: rtl/branch_table_scheduler_if.sv
// Lookup / feedback-update bundle between branch_controller (master) and the
// pattern-table scheduler (slave).
interface branch_table_scheduler_if
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = TABLE_INDEX_WIDTH,
    parameter int CTR_WIDTH   = TABLE_CTR_WIDTH
);

    logic                   i_lk_valid;
    logic [INDEX_WIDTH-1:0] i_lk_index;
    logic                   o_lk_ready;
    logic                   o_lk_valid;
    logic [CTR_WIDTH-1:0]   o_lk_counter;

    logic                   i_up_valid;
    logic [INDEX_WIDTH-1:0] i_up_index;
    BranchOutcome           i_up_outcome;
    logic                   o_up_full;
    logic                   o_up_drop;

    logic                   o_init_done;

    modport master (
        output i_lk_valid, i_lk_index, i_up_valid, i_up_index, i_up_outcome,
        input  o_lk_ready, o_lk_valid, o_lk_counter, o_up_full, o_up_drop,
               o_init_done
    );

    modport slave (
        input  i_lk_valid, i_lk_index, i_up_valid, i_up_index, i_up_outcome,
        output o_lk_ready, o_lk_valid, o_lk_counter, o_up_full, o_up_drop,
               o_init_done
    );

endinterface

// File: rtl/sat_counter_ram.sv
// Single-port counter storage: synchronous read, write enable, no reset.
module sat_counter_ram #(
    parameter int INDEX_WIDTH = 12,
    parameter int CTR_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] addr,
    input  logic [CTR_WIDTH-1:0]   wdata,
    output logic [CTR_WIDTH-1:0]   rdata
);

    logic [CTR_WIDTH-1:0] mem [2**INDEX_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/branch_table_scheduler.sv
// Shares one table port between decode lookups and queued execute feedback
// updates (two-cycle read-modify-write); clears the table after reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | sweep writes INIT_VALUE to every entry, one per cycle
// IDLE     | serve lookups; start an update when the queue wins
// UP_READ  | read the counter addressed by the queue head
// UP_WRITE | write the saturated counter back and pop the head
module branch_table_scheduler
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = TABLE_INDEX_WIDTH,
    parameter int CTR_WIDTH   = TABLE_CTR_WIDTH,
    parameter int QUEUE_DEPTH = 4,
    parameter int INIT_VALUE  = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    branch_table_scheduler_if.slave bus
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [CTR_WIDTH-1:0]   CTR_MAX   = '1;
    localparam logic [CTR_WIDTH-1:0]   CTR_INIT  = CTR_WIDTH'(INIT_VALUE);

    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two and at least 2");
    end

    TableSchedState         state;
    logic [INDEX_WIDTH-1:0] init_addr;

    logic [INDEX_WIDTH-1:0] q_index   [QUEUE_DEPTH];
    BranchOutcome           q_outcome [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;

    logic q_empty, q_full, push, pop, push_ok;
    logic lk_ready, lk_fire;

    logic                   ram_we;
    logic [INDEX_WIDTH-1:0] ram_addr;
    logic [CTR_WIDTH-1:0]   ram_wdata;
    logic [CTR_WIDTH-1:0]   ram_rdata;
    logic [CTR_WIDTH-1:0]   upd_value;

    logic                 lk_valid_q;
    logic [CTR_WIDTH-1:0] lk_hold_q;
    logic                 full_q;
    logic                 drop_q;
    logic                 init_done_q;

    assign q_empty = (count == '0);
    assign q_full  = (count == DEPTH_CNT);
    assign pop     = (state == UP_WRITE);
    assign push    = bus.i_up_valid;
    assign push_ok = push && (!q_full || pop);

    // A full queue blocks lookups so queued updates cannot starve.
    assign lk_ready = (state == IDLE) && (q_empty || (!q_full && bus.i_lk_valid));
    assign lk_fire  = lk_ready && bus.i_lk_valid;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        upd_value = ram_rdata;
        if (q_outcome[rd_ptr] == TAKEN) begin
            if (ram_rdata != CTR_MAX) upd_value = ram_rdata + 1'b1;
        end else begin
            if (ram_rdata != '0) upd_value = ram_rdata - 1'b1;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = q_index[rd_ptr];
        ram_wdata = upd_value;
        case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_addr  = init_addr;
                ram_wdata = CTR_INIT;
            end
            IDLE: begin
                if (lk_fire) ram_addr = bus.i_lk_index;
            end
            UP_WRITE: ram_we = 1'b1;
            default: ;
        endcase
    end

    sat_counter_ram #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .CTR_WIDTH   (CTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_q <= (count_next == DEPTH_CNT);
            drop_q <= push && !push_ok;
        end
    end

    // Entry payload needs no reset; only slots below count are ever consumed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_index[wr_ptr]   <= bus.i_up_index;
            q_outcome[wr_ptr] <= bus.i_up_outcome;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            init_addr   <= '0;
            init_done_q <= 1'b0;
            lk_valid_q  <= 1'b0;
            lk_hold_q   <= '0;
        end else begin
            lk_valid_q <= lk_fire;
            if (lk_valid_q) lk_hold_q <= ram_rdata;
            case (state)
                INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == LAST_ADDR) begin
                        state       <= IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                IDLE: begin
                    // An arriving push counts, so an empty-queue update starts next cycle.
                    if (!lk_fire && (!q_empty || push_ok)) state <= UP_READ;
                end
                UP_READ:  state <= UP_WRITE;
                UP_WRITE: state <= IDLE;
                default:  state <= INIT;
            endcase
        end
    end

    // Data shows straight from the RAM in the valid cycle, then from the hold register.
    assign bus.o_lk_ready   = lk_ready;
    assign bus.o_lk_valid   = lk_valid_q;
    assign bus.o_lk_counter = lk_valid_q ? ram_rdata : lk_hold_q;
    assign bus.o_up_full    = full_q;
    assign bus.o_up_drop    = drop_q;
    assign bus.o_init_done  = init_done_q;

endmodule

// File: tb/tb_branch_table_scheduler.sv
// Directed bench for branch_table_scheduler: init sweep, saturation, queue
// ordering, full/drop arbitration and reset during an update.
module tb_branch_table_scheduler;
    import mips_core_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    branch_table_scheduler_if #(.INDEX_WIDTH(12), .CTR_WIDTH(2)) bus ();

    branch_table_scheduler #(
        .INDEX_WIDTH (12),
        .CTR_WIDTH   (2),
        .QUEUE_DEPTH (4),
        .INIT_VALUE  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] idx, input BranchOutcome oc);
        bus.i_up_valid   = 1'b1;
        bus.i_up_index   = idx;
        bus.i_up_outcome = oc;
        tick();
        bus.i_up_valid   = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic lookup_check(input string tag, input logic [11:0] idx, input logic [1:0] exp);
        int n;
        n = 0;
        bus.i_lk_valid = 1'b1;
        bus.i_lk_index = idx;
        #1;
        while (!bus.o_lk_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready_budget"}, 32'(n < 50), 1);
        tick();
        bus.i_lk_valid = 1'b0;
        check({tag, "_valid"}, 32'(bus.o_lk_valid), 1);
        check(tag, 32'(bus.o_lk_counter), 32'(exp));
    endtask

    task automatic wait_init(output int cycles, output bit saw_ready);
        cycles    = 0;
        saw_ready = 1'b0;
        while (!bus.o_init_done && cycles < 5000) begin
            tick();
            cycles++;
            if (!bus.o_init_done && bus.o_lk_ready) saw_ready = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lk_ready"},   32'(bus.o_lk_ready),   0);
        check({tag, "_lk_valid"},   32'(bus.o_lk_valid),   0);
        check({tag, "_lk_counter"}, 32'(bus.o_lk_counter), 0);
        check({tag, "_up_full"},    32'(bus.o_up_full),    0);
        check({tag, "_up_drop"},    32'(bus.o_up_drop),    0);
        check({tag, "_init_done"},  32'(bus.o_init_done),  0);
    endtask

    initial begin
        int cycles;
        bit saw_ready;

        bus.i_lk_valid   = 1'b1;
        bus.i_lk_index   = 12'hABC;
        bus.i_up_valid   = 1'b0;
        bus.i_up_index   = '0;
        bus.i_up_outcome = NOT_TAKEN;

        // Reset values, then the init sweep with a lookup held pending.
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_init(cycles, saw_ready);
        check("init_cycles", 32'(cycles), 4096);
        check("init_no_early_ready", 32'(saw_ready), 0);
        check("init_ready_after", 32'(bus.o_lk_ready), 1);
        tick();
        bus.i_lk_valid = 1'b0;
        check("init_lk_valid", 32'(bus.o_lk_valid), 1);
        check("init_lk_value", 32'(bus.o_lk_counter), 1);
        tick();
        check("lk_valid_pulse", 32'(bus.o_lk_valid), 0);
        check("lk_counter_hold", 32'(bus.o_lk_counter), 1);

        // Saturation up and down at index 5.
        push(12'd5, TAKEN);
        push(12'd5, TAKEN);
        push(12'd5, TAKEN);
        idle_wait(15);
        lookup_check("sat_up3", 12'd5, 2'd3);
        push(12'd5, TAKEN);
        idle_wait(10);
        lookup_check("sat_up4", 12'd5, 2'd3);
        push(12'd5, NOT_TAKEN);
        push(12'd5, NOT_TAKEN);
        push(12'd5, NOT_TAKEN);
        push(12'd5, NOT_TAKEN);
        idle_wait(20);
        lookup_check("sat_down", 12'd5, 2'd0);

        // Best-case update latency at index 9.
        idle_wait(2);
        push(12'd9, TAKEN);
        bus.i_lk_valid = 1'b1;
        bus.i_lk_index = 12'd9;
        #1;
        check("lat_up_read_ready", 32'(bus.o_lk_ready), 0);
        tick();
        check("lat_up_write_ready", 32'(bus.o_lk_ready), 0);
        tick();
        check("lat_idle_ready", 32'(bus.o_lk_ready), 1);
        tick();
        bus.i_lk_valid = 1'b0;
        check("lat_lk_valid", 32'(bus.o_lk_valid), 1);
        check("lat_lk_value", 32'(bus.o_lk_counter), 2);

        // Same-index updates while lookups stream: no forwarding, no lost update.
        idle_wait(2);
        bus.i_lk_valid   = 1'b1;
        bus.i_lk_index   = 12'd7;
        bus.i_up_valid   = 1'b1;
        bus.i_up_index   = 12'd7;
        bus.i_up_outcome = TAKEN;
        tick();
        tick();
        bus.i_up_outcome = NOT_TAKEN;
        tick();
        bus.i_up_valid = 1'b0;
        check("same_stream_valid", 32'(bus.o_lk_valid), 1);
        check("same_stream_stale", 32'(bus.o_lk_counter), 1);
        bus.i_lk_valid = 1'b0;
        idle_wait(15);
        lookup_check("same_idx7", 12'd7, 2'd2);

        // Full queue under continuous lookups, drop, then push/pop while full.
        idle_wait(2);
        bus.i_lk_valid   = 1'b1;
        bus.i_lk_index   = 12'd30;
        bus.i_up_valid   = 1'b1;
        bus.i_up_outcome = TAKEN;
        bus.i_up_index   = 12'd20;
        tick();
        bus.i_up_index   = 12'd21;
        tick();
        bus.i_up_index   = 12'd22;
        tick();
        bus.i_up_index   = 12'd23;
        tick();
        check("full_flag", 32'(bus.o_up_full), 1);
        check("full_ready", 32'(bus.o_lk_ready), 0);
        check("full_lk_valid", 32'(bus.o_lk_valid), 1);
        check("full_no_drop_yet", 32'(bus.o_up_drop), 0);
        bus.i_up_index   = 12'd24;
        tick();
        bus.i_up_valid   = 1'b0;
        check("drop_pulse", 32'(bus.o_up_drop), 1);
        check("drop_ready", 32'(bus.o_lk_ready), 0);
        check("drop_lk_blocked", 32'(bus.o_lk_valid), 0);
        tick();
        check("drop_pulse_end", 32'(bus.o_up_drop), 0);
        check("upwrite_full", 32'(bus.o_up_full), 1);
        bus.i_up_valid   = 1'b1;
        bus.i_up_index   = 12'd25;
        tick();
        bus.i_up_valid   = 1'b0;
        check("pushpop_no_drop", 32'(bus.o_up_drop), 0);
        check("pushpop_full", 32'(bus.o_up_full), 1);
        check("pushpop_ready", 32'(bus.o_lk_ready), 0);
        bus.i_lk_valid = 1'b0;
        idle_wait(20);
        check("drained_full", 32'(bus.o_up_full), 0);
        lookup_check("q_idx20", 12'd20, 2'd2);
        lookup_check("q_idx24_dropped", 12'd24, 2'd1);
        lookup_check("q_idx25_pushpop", 12'd25, 2'd2);

        // Reset while an update is in UP_READ.
        idle_wait(2);
        push(12'd40, TAKEN);
        #1;
        check("mid_up_read_ready", 32'(bus.o_lk_ready), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        tick();
        rst_n = 1'b1;
        push(12'd50, TAKEN);
        wait_init(cycles, saw_ready);
        check("reinit_cycles", 32'(cycles + 1), 4096);
        check("reinit_no_early_ready", 32'(saw_ready), 0);
        idle_wait(10);
        check("reinit_empty_ready", 32'(bus.o_lk_ready), 1);
        lookup_check("reinit_idx40_aborted", 12'd40, 2'd1);
        lookup_check("reinit_idx50_init_push", 12'd50, 2'd2);
        lookup_check("reinit_idx5", 12'd5, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
